mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage RISC-V pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes its destination, write-enable, data, address and ALU-op fields. It performs RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) over a byte-wide synchronous RAM port, stalling the pipeline for the transfer. It hands the write-back triple (wd, wreg, wdata) to the MEM/WB register.

## Interface
- MEM_ADDR_W, 17, byte-address bits driven to the RAM.
- AOP_W, 8, ALU-op field width; matches the shared AluOpBus width.

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wd_i  in  5  destination register from EX/MEM
- wreg_i  in  1  register-write enable from EX/MEM
- data_i  in  32  ALU result (non-memory ops) or store data (stores)
- addr_i  in  32  effective byte address
- aluop_i  in  AOP_W  operation code
- wd_o  out  5  destination register to MEM/WB
- wreg_o  out  1  write enable to MEM/WB
- wdata_o  out  32  write-back data
- stall_req_o  out  1  hold IF..EX/MEM; EX/MEM inputs stay stable while high
- ram_addr_o  out  MEM_ADDR_W  RAM byte address (addr_i truncated, plus byte offset)
- ram_wr_o  out  1  RAM write strobe
- ram_dout_o  out  8  RAM write byte
- ram_din_i  in  8  RAM read byte, valid one cycle after its address is presented

## Operation
- FSM states: IDLE, LOAD, STORE, DONE. Byte counter cnt is 2 bits. Byte buffer is 32 bits.
- N (transfer size) = 1 for B/BU, 2 for H/HU, 4 for W. Byte order is little-endian. There is no alignment requirement.
- Non-memory aluop (any code not listed above) in IDLE:
  - Combinational pass-through: wd_o=wd_i, wreg_o=wreg_i, wdata_o=data_i.
  - stall_req_o=0; no RAM activity.
- Load, IDLE cycle:
  - Outputs: ram_addr_o=addr_i, stall_req_o=1, ram_wr_o=0.
  - Next: state LOAD, cnt=1.
- LOAD with cnt=k:
  - Capture ram_din_i into buffer byte k-1; stall_req_o=1.
  - If k<N: drive addr_i+k and increment cnt. Otherwise go to DONE.
- Store, IDLE cycle:
  - Outputs: ram_addr_o=addr_i, ram_wr_o=1, ram_dout_o=data_i[7:0], stall_req_o=1.
  - Next: DONE if N=1, else STORE with cnt=1.
- STORE with cnt=k:
  - Drive addr_i+k with data_i byte k, ram_wr_o=1, stall_req_o=1.
  - If k=N-1 go to DONE, else increment cnt.
- DONE:
  - stall_req_o=0, wd_o=wd_i.
  - Load: wreg_o=wreg_i, wdata_o = buffer sign-extended (LB/LH) or zero-extended (LBU/LHU/LW).
  - Store: wreg_o=0 and wdata_o=0, regardless of wreg_i.
  - Next: IDLE unconditionally. DONE exists so the still-present memory op is not re-triggered.
- Address arithmetic is modulo 2^MEM_ADDR_W; addr_i+k wraps from the top of RAM to 0.
- ram_wr_o=0 in every cycle outside store issue; ram_dout_o holds its last value there.

## Timing
- Reset (rst high at edge): state IDLE, cnt=0, buffer=0.
  - While rst is high, all outputs are forced to 0: wd_o, wreg_o, wdata_o, stall_req_o, ram_addr_o, ram_wr_o, ram_dout_o.
- Reset mid-transfer aborts immediately. Bytes of a store already written remain in RAM; a partial store is acceptable and is not retried.
- Latency: non-memory ops take 0 extra cycles.
  - Load: N+1 stall cycles, result in cycle N+1.
  - Store: N stall cycles, DONE in cycle N.
- Back-to-back memory ops: the next op is detected in the IDLE cycle after DONE, with no gap cycle beyond DONE.
- Upstream contract: while stall_req_o=1, EX/MEM holds all inputs; the block does not latch them.
- An aluop change while not in IDLE is a protocol violation and its behaviour is unspecified.

## Structure
- The shared defines header holds the load/store aluop encodings (LB, LH, LW, LBU, LHU, SB, SH, SW), RegBus, RegAddrBus, AluOpBus and RstEnable.
- The FSM state encoding is local to this module.
- Optional sub-module: mem_ext, a combinational size/sign extension of the buffer keyed by aluop. Everything else stays in one module.

## Test plan
- Non-memory op: wd_i=5, wreg_i=1, data_i=0x1234_5678 -> same cycle wd_o=5, wreg_o=1, wdata_o=0x1234_5678, stall_req_o=0, ram_wr_o=0.
- SW to addr 0x100 with data 0xDEAD_BEEF:
  - Writes EF, BE, AD, DE to 0x100..0x103 on 4 consecutive cycles with stall_req_o=1.
  - Then one DONE cycle with wreg_o=0.
- LW from 0x100 after the SW:
  - wdata_o=0xDEAD_BEEF with wreg_o=1 on cycle 5; stall_req_o high for cycles 0..4.
  - LB from 0x103 -> 0xFFFF_FFDE; LBU from 0x103 -> 0x0000_00DE; LH from 0x102 -> 0xFFFF_DEAD.
- Wrap-around: SH of 0xA55A to addr 0x1FFFF (MEM_ADDR_W=17) -> 0x5A at 0x1FFFF, 0xA5 at 0x00000. LHU from the same address -> 0x0000_A55A.
- Reset mid-SW after 2 bytes to 0x200:
  - Only 0x200 and 0x201 are modified; all outputs are 0 while rst is high.
  - The following LW from 0x300 completes normally.
- Back-to-back SB then LBU to the same address -> stall_req_o sequence 1,0,1,1,0; LBU returns the stored byte.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared load/store aluop encodings, bus typedefs and transfer-size helpers
// for the RV32I memory-access stage.
package mem_stage_pkg;

  localparam int DEF_MEM_ADDR_W = 17;
  localparam int DEF_AOP_W      = 8;

  typedef logic [31:0] reg_bus_t;
  typedef logic [4:0]  reg_addr_bus_t;
  typedef logic [7:0]  alu_op_bus_t;

  localparam logic RST_ENABLE = 1'b1;

  localparam alu_op_bus_t EXE_LB_OP  = 8'h20;
  localparam alu_op_bus_t EXE_LH_OP  = 8'h21;
  localparam alu_op_bus_t EXE_LW_OP  = 8'h23;
  localparam alu_op_bus_t EXE_LBU_OP = 8'h24;
  localparam alu_op_bus_t EXE_LHU_OP = 8'h25;
  localparam alu_op_bus_t EXE_SB_OP  = 8'h28;
  localparam alu_op_bus_t EXE_SH_OP  = 8'h29;
  localparam alu_op_bus_t EXE_SW_OP  = 8'h2B;

  function automatic logic is_load(input alu_op_bus_t op);
    return (op == EXE_LB_OP) || (op == EXE_LH_OP) || (op == EXE_LW_OP) ||
           (op == EXE_LBU_OP) || (op == EXE_LHU_OP);
  endfunction

  function automatic logic is_store(input alu_op_bus_t op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  // Bytes moved by the op; non-memory codes report 1 so counters stay bounded.
  function automatic logic [2:0] xfer_size(input alu_op_bus_t op);
    if ((op == EXE_LH_OP) || (op == EXE_LHU_OP) || (op == EXE_SH_OP)) return 3'd2;
    if ((op == EXE_LW_OP) || (op == EXE_SW_OP)) return 3'd4;
    return 3'd1;
  endfunction

endpackage

// File: rtl/mem_stage_ext.sv
// Size/sign extension of the assembled load buffer, keyed by the load aluop.
module mem_stage_ext
  import mem_stage_pkg::*;
(
  input  alu_op_bus_t aluop_i,
  input  logic [31:0] bytes_i,
  output logic [31:0] data_o
);

  always_comb begin
    case (aluop_i)
      EXE_LB_OP:  data_o = {{24{bytes_i[7]}}, bytes_i[7:0]};
      EXE_LH_OP:  data_o = {{16{bytes_i[15]}}, bytes_i[15:0]};
      EXE_LBU_OP: data_o = {24'd0, bytes_i[7:0]};
      EXE_LHU_OP: data_o = {16'd0, bytes_i[15:0]};
      default:    data_o = bytes_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: byte-serial loads/stores over a synchronous
// byte RAM, stalling the upstream pipeline for the duration of the transfer.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MEM_ADDR_W = DEF_MEM_ADDR_W,
  parameter int AOP_W      = DEF_AOP_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            wd_i,
  input  logic                  wreg_i,
  input  logic [31:0]           data_i,
  input  logic [31:0]           addr_i,
  input  logic [AOP_W-1:0]      aluop_i,
  output logic [4:0]            wd_o,
  output logic                  wreg_o,
  output logic [31:0]           wdata_o,
  output logic                  stall_req_o,
  output logic [MEM_ADDR_W-1:0] ram_addr_o,
  output logic                  ram_wr_o,
  output logic [7:0]            ram_dout_o,
  input  logic [7:0]            ram_din_i
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;
  logic [7:0]  dout_q, dout_d;
  logic [2:0]  n, k, off;
  logic [1:0]  idx;
  logic        ld, st;
  logic [31:0] ext_data;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^addr_i[31:MEM_ADDR_W];
  assign ld  = is_load(aluop_i);
  assign st  = is_store(aluop_i);
  assign n   = xfer_size(aluop_i);
  // cnt wraps 3->0 during a word load; 0 then stands for the fourth byte
  assign k   = (cnt_q == 2'd0) ? 3'd4 : {1'b0, cnt_q};
  assign idx = cnt_q - 2'd1;

  mem_stage_ext u_ext (
    .aluop_i (aluop_i),
    .bytes_i (buf_q),
    .data_o  (ext_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    dout_d      = dout_q;
    off         = 3'd0;
    wd_o        = wd_i;
    wreg_o      = 1'b0;
    wdata_o     = '0;
    stall_req_o = 1'b0;
    ram_wr_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ld) begin
          stall_req_o = 1'b1;
          state_d     = S_LOAD;
          cnt_d       = 2'd1;
        end else if (st) begin
          stall_req_o = 1'b1;
          ram_wr_o    = 1'b1;
          dout_d      = data_i[7:0];
          state_d     = (n == 3'd1) ? S_DONE : S_STORE;
          cnt_d       = 2'd1;
        end else begin
          wreg_o  = wreg_i;
          wdata_o = data_i;
        end
      end
      S_LOAD: begin
        stall_req_o                = 1'b1;
        buf_d[{idx, 3'b000} +: 8] = ram_din_i;
        if (k < n) begin
          off   = k;
          cnt_d = cnt_q + 2'd1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_STORE: begin
        stall_req_o = 1'b1;
        ram_wr_o    = 1'b1;
        off         = k;
        dout_d      = data_i[{cnt_q, 3'b000} +: 8];
        if (k == n - 3'd1) state_d = S_DONE;
        else               cnt_d   = cnt_q + 2'd1;
      end
      S_DONE: begin
        // Stores retire without a register write regardless of wreg_i
        if (!st) begin
          wreg_o  = wreg_i;
          wdata_o = ext_data;
        end
        state_d = S_IDLE;
        cnt_d   = 2'd0;
      end
      default: state_d = S_IDLE;
    endcase
    ram_dout_o = dout_d;
    ram_addr_o = addr_i[MEM_ADDR_W-1:0] + MEM_ADDR_W'(off);
    if (rst == RST_ENABLE) begin
      wd_o        = '0;
      wreg_o      = 1'b0;
      wdata_o     = '0;
      stall_req_o = 1'b0;
      ram_addr_o  = '0;
      ram_wr_o    = 1'b0;
      ram_dout_o  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      buf_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand-written
// reset/back-to-back sequences and randomized ops against a byte-map model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int AW = 17;
  localparam int MASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    wd_i;
  logic          wreg_i;
  logic [31:0]   data_i;
  logic [31:0]   addr_i;
  logic [7:0]    aluop_i;
  logic [4:0]    wd_o;
  logic          wreg_o;
  logic [31:0]   wdata_o;
  logic          stall_req_o;
  logic [AW-1:0] ram_addr_o;
  logic          ram_wr_o;
  logic [7:0]    ram_dout_o;
  logic [7:0]    ram_din_i;

  mem_stage #(.MEM_ADDR_W(AW), .AOP_W(8)) dut (
    .clk(clk), .rst(rst), .wd_i(wd_i), .wreg_i(wreg_i), .data_i(data_i),
    .addr_i(addr_i), .aluop_i(aluop_i), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .stall_req_o(stall_req_o), .ram_addr_o(ram_addr_o),
    .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM: read data appears the cycle after the address.
  logic [7:0] ram [0:(1<<AW)-1] = '{default: 8'h00};
  always @(posedge clk) begin
    if (ram_wr_o) ram[ram_addr_o] <= ram_dout_o;
    ram_din_i <= ram[ram_addr_o];
  end

  int checks = 0;
  int failures = 0;
  logic [7:0] ref_mem [int];
  logic [7:0] last_dout;
  bit dout_known = 0;

  int          o_stall_cycles;
  logic [4:0]  o_wd;
  logic        o_wreg;
  logic [31:0] o_wdata;
  logic [7:0]  o_dout;
  int          wr_addr_q[$];
  logic [7:0]  wr_byte_q[$];
  bit          stall_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int op_size(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 1;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2;
      EXE_LW_OP, EXE_SW_OP:             return 4;
      default:                          return 0;
    endcase
  endfunction

  function automatic bit op_is_store(input logic [7:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  function automatic logic [7:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // Caller must be just after a rising edge; returns just after a rising edge.
  task automatic run_op(input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] data, input logic [4:0] wd, input logic wreg);
    int cyc;
    aluop_i = op; addr_i = addr; data_i = data; wd_i = wd; wreg_i = wreg;
    wr_addr_q.delete();
    wr_byte_q.delete();
    cyc = 0;
    forever begin
      @(negedge clk);
      stall_log.push_back(stall_req_o);
      if (ram_wr_o) begin
        wr_addr_q.push_back(int'(ram_addr_o));
        wr_byte_q.push_back(ram_dout_o);
      end
      if (!stall_req_o) break;
      cyc++;
      if (cyc > 10) begin
        failures++;
        checks++;
        $display("FAIL op_timeout: got stall still high after %0d cycles expected release", cyc);
        break;
      end
      @(posedge clk); #1;
    end
    o_stall_cycles = cyc;
    o_wd = wd_o; o_wreg = wreg_o; o_wdata = wdata_o; o_dout = ram_dout_o;
    @(posedge clk); #1;
  endtask

  task automatic do_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [4:0] wd, input logic wreg, input string tag);
    int n;
    logic [31:0] exp;
    n = op_size(op);
    run_op(op, addr, data, wd, wreg);
    chk({tag, ".wd"}, 32'(o_wd), 32'(wd));
    if (n == 0) begin
      chk({tag, ".stall"}, o_stall_cycles, 0);
      chk({tag, ".wreg"}, 32'(o_wreg), 32'(wreg));
      chk({tag, ".wdata"}, o_wdata, data);
      chk({tag, ".nwr"}, wr_addr_q.size(), 0);
    end else if (op_is_store(op)) begin
      chk({tag, ".stall"}, o_stall_cycles, n);
      chk({tag, ".wreg"}, 32'(o_wreg), 0);
      chk({tag, ".wdata"}, o_wdata, 0);
      chk({tag, ".nwr"}, wr_addr_q.size(), n);
      for (int i = 0; i < n; i++) begin
        if (i < wr_addr_q.size()) begin
          chk($sformatf("%s.wa%0d", tag, i), wr_addr_q[i], (int'(addr) + i) & MASK);
          chk($sformatf("%s.wb%0d", tag, i), 32'(wr_byte_q[i]), 32'((data >> (8 * i)) & 32'hFF));
        end
        ref_mem[(int'(addr) + i) & MASK] = 8'((data >> (8 * i)) & 32'hFF);
      end
      last_dout = 8'((data >> (8 * (n - 1))) & 32'hFF);
      dout_known = 1;
      chk({tag, ".dout"}, 32'(o_dout), 32'(last_dout));
    end else begin
      exp = 0;
      for (int i = 0; i < n; i++) exp |= 32'(ref_rd((int'(addr) + i) & MASK)) << (8 * i);
      if (op == EXE_LB_OP && exp[7])  exp |= 32'hFFFF_FF00;
      if (op == EXE_LH_OP && exp[15]) exp |= 32'hFFFF_0000;
      chk({tag, ".stall"}, o_stall_cycles, n + 1);
      chk({tag, ".wreg"}, 32'(o_wreg), 32'(wreg));
      chk({tag, ".wdata"}, o_wdata, exp);
      chk({tag, ".nwr"}, wr_addr_q.size(), 0);
      if (dout_known) chk({tag, ".dout"}, 32'(o_dout), 32'(last_dout));
    end
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] exp_wdata;
    int          exp_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [71:0] all_outs();
    return {wd_o, wreg_o, wdata_o, stall_req_o, 15'(ram_addr_o), ram_wr_o, ram_dout_o, 9'd0};
  endfunction

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs.push_back('{8'h00,      32'h0,         32'h1234_5678, 5'd5,  1'b1, 32'h1234_5678, 0});
    vecs.push_back('{EXE_SW_OP,  32'h100,       32'hDEAD_BEEF, 5'd3,  1'b1, 32'h0,         4});
    vecs.push_back('{EXE_LW_OP,  32'h100,       32'h0,         5'd7,  1'b1, 32'hDEAD_BEEF, 5});
    vecs.push_back('{EXE_LB_OP,  32'h103,       32'h0,         5'd8,  1'b1, 32'hFFFF_FFDE, 2});
    vecs.push_back('{EXE_LBU_OP, 32'h103,       32'h0,         5'd9,  1'b1, 32'h0000_00DE, 2});
    vecs.push_back('{EXE_LH_OP,  32'h102,       32'h0,         5'd10, 1'b1, 32'hFFFF_DEAD, 3});
    vecs.push_back('{EXE_SH_OP,  32'h1FFFF,     32'h0000_A55A, 5'd11, 1'b1, 32'h0,         2});
    vecs.push_back('{EXE_LHU_OP, 32'h1FFFF,     32'h0,         5'd12, 1'b1, 32'h0000_A55A, 3});
    vecs.push_back('{EXE_LW_OP,  32'h1234_0100, 32'h0,         5'd13, 1'b0, 32'hDEAD_BEEF, 5});

    rst = 1'b1;
    aluop_i = 8'h00; addr_i = 32'h1234; data_i = 32'hFFFF_FFFF; wd_i = 5'd31; wreg_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 32'(all_outs() >> 40), 32'h0);
    chk("reset_outs_lo", 32'(all_outs()), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].wd, vecs[i].wreg,
            $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_wdata", i), o_wdata, vecs[i].exp_wdata);
      chk($sformatf("vec%0d.tbl_stall", i), o_stall_cycles, vecs[i].exp_stall);
    end
    chk("wrap_top", 32'(ram[17'h1FFFF]), 32'h5A);
    chk("wrap_zero", 32'(ram[17'h00000]), 32'hA5);

    // Reset in the middle of a word store: two bytes land, rest untouched.
    do_op(EXE_SW_OP, 32'h300, 32'hCAFE_F00D, 5'd1, 1'b0, "pre_sw");
    aluop_i = EXE_SW_OP; addr_i = 32'h200; data_i = 32'h1122_3344; wd_i = 5'd2; wreg_i = 1'b1;
    @(negedge clk);
    chk("abort.b0", {ram_wr_o, 7'd0, 15'(ram_addr_o), ram_dout_o}, {1'b1, 7'd0, 15'h200, 8'h44});
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort.b1", {ram_wr_o, 7'd0, 15'(ram_addr_o), ram_dout_o}, {1'b1, 7'd0, 15'h201, 8'h33});
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort.outs_hi", 32'(all_outs() >> 40), 32'h0);
    chk("abort.outs_lo", 32'(all_outs()), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    dout_known = 0;
    ref_mem[32'h200] = 8'h44;
    ref_mem[32'h201] = 8'h33;
    do_op(EXE_LW_OP, 32'h300, 32'h0, 5'd4, 1'b1, "post_abort_lw");
    chk("post_abort_lw.val", o_wdata, 32'hCAFE_F00D);
    chk("abort.m200", 32'(ram[17'h200]), 32'h44);
    chk("abort.m201", 32'(ram[17'h201]), 32'h33);
    chk("abort.m202", 32'(ram[17'h202]), 32'h00);
    chk("abort.m203", 32'(ram[17'h203]), 32'h00);

    // Back-to-back SB then LBU with no gap beyond DONE.
    stall_log.delete();
    do_op(EXE_SB_OP, 32'h50, 32'h0000_007E, 5'd6, 1'b1, "b2b_sb");
    do_op(EXE_LBU_OP, 32'h50, 32'h0, 5'd6, 1'b1, "b2b_lbu");
    chk("b2b.val", o_wdata, 32'h7E);
    chk("b2b.len", stall_log.size(), 5);
    if (stall_log.size() == 5)
      chk("b2b.seq", {27'd0, stall_log[0], stall_log[1], stall_log[2], stall_log[3], stall_log[4]},
          32'b10110);

    for (int t = 0; t < 80; t++) begin
      logic [7:0]  op;
      logic [31:0] addr;
      int          sel;
      sel = $urandom_range(0, 8);
      case (sel)
        0: op = EXE_LB_OP;  1: op = EXE_LH_OP;  2: op = EXE_LW_OP;
        3: op = EXE_LBU_OP; 4: op = EXE_LHU_OP; 5: op = EXE_SB_OP;
        6: op = EXE_SH_OP;  7: op = EXE_SW_OP;
        default: begin
          op = 8'($urandom_range(0, 255));
          if (op_size(op) != 0) op = 8'h00;
        end
      endcase
      case ($urandom_range(0, 2))
        0: addr = 32'h1FFFC + 32'($urandom_range(0, 3));
        1: addr = 32'($urandom_range(0, 15));
        default: addr = $urandom;
      endcase
      do_op(op, addr, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            $sformatf("rnd%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
